// File: rtl/uart_cmd_link_if.sv
// Command-processor side of uart_cmd_link: received command, response trigger/byte and tx status.
// master = command processor, slave = the serial link.
interface uart_cmd_link_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        trmt;
  logic [7:0]  resp;
  logic        tx_done;

  modport master (
    output clr_cmd_rdy, trmt, resp,
    input  cmd, cmd_rdy, tx_done
  );

  modport slave (
    input  clr_cmd_rdy, trmt, resp,
    output cmd, cmd_rdy, tx_done
  );
endinterface

// File: rtl/uart_cmd_link.sv
// 8N1 UART link: two received bytes (high first) form a 16-bit command; one response byte is sent back.
// Optional `CMD_TIMEOUT_EN drops a stale high byte after three idle frame times.
module uart_cmd_link #(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RX,
  output logic            TX,
  uart_cmd_link_if.slave  cmd_if
);

  localparam logic [15:0] BAUD_FULL = 16'(BAUD_DIV);
  localparam logic [15:0] BAUD_HALF = 16'(BAUD_DIV / 2);

  typedef enum logic { R_IDLE, R_SHIFT } rx_state_t;
  typedef enum logic { A_HI,   A_LO    } asm_state_t;
  typedef enum logic { T_IDLE, T_SHIFT } tx_state_t;

  // ---------------- RX synchronizer and engine ----------------
  logic       r_rx_sync1, r_rx_sync2, r_rx_prev;
  rx_state_t  r_rx_state, w_rx_next;
  logic [15:0] r_rx_cnt;
  logic [3:0]  r_rx_bits;
  logic [7:0]  r_rx_shift;
  logic        r_byte_rdy;
  logic        w_rx_fall, w_rx_tick, w_rx_start, w_rx_sample, w_rx_good;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_sync1 <= 1'b1;
      r_rx_sync2 <= 1'b1;
      r_rx_prev  <= 1'b1;
    end else begin
      r_rx_sync1 <= RX;
      r_rx_sync2 <= r_rx_sync1;
      r_rx_prev  <= r_rx_sync2;
    end
  end

  assign w_rx_fall = r_rx_prev & ~r_rx_sync2;
  assign w_rx_tick = (r_rx_cnt == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= R_IDLE;
    else     r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      R_IDLE:  if (w_rx_fall) w_rx_next = R_SHIFT;
      R_SHIFT: if (w_rx_tick) begin
        if ((r_rx_bits == 4'd0 && r_rx_sync2) || r_rx_bits == 4'd9) w_rx_next = R_IDLE;
      end
      default: w_rx_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_rx_start  = (r_rx_state == R_IDLE) && w_rx_fall;
    w_rx_sample = (r_rx_state == R_SHIFT) && w_rx_tick;
    w_rx_good   = w_rx_sample && (r_rx_bits == 4'd9) && r_rx_sync2;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_byte_rdy <= 1'b0;
    end else begin
      r_byte_rdy <= w_rx_good;
      if (w_rx_start) begin
        r_rx_cnt  <= BAUD_HALF;
        r_rx_bits <= '0;
      end else if (w_rx_sample) begin
        r_rx_cnt  <= BAUD_FULL;
        r_rx_bits <= r_rx_bits + 4'd1;
        if (r_rx_bits >= 4'd1 && r_rx_bits <= 4'd8)
          r_rx_shift <= {r_rx_sync2, r_rx_shift[7:1]};
      end else if (r_rx_state == R_SHIFT) begin
        r_rx_cnt <= r_rx_cnt - 16'd1;
      end else begin
        r_rx_cnt <= '0;
      end
    end
  end

  // ---------------- Command assembly ----------------
  asm_state_t  r_asm_state, w_asm_next;
  logic [7:0]  r_hi;
  logic [15:0] r_cmd;
  logic        r_cmd_rdy;
  logic        w_hi_load, w_cmd_load, w_to_hit;

`ifdef CMD_TIMEOUT_EN
  localparam logic [21:0] TO_LIMIT = 22'(30 * BAUD_DIV);
  logic [21:0] r_to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_to_cnt <= '0;
    else if (w_hi_load)            r_to_cnt <= '0;
    else if (r_asm_state == A_LO)  r_to_cnt <= r_to_cnt + 22'd1;
  end

  assign w_to_hit = (r_asm_state == A_LO) && !r_byte_rdy && (r_to_cnt == TO_LIMIT);
`else
  assign w_to_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_asm_state <= A_HI;
    else     r_asm_state <= w_asm_next;
  end

  always_comb begin
    w_asm_next = r_asm_state;
    case (r_asm_state)
      A_HI:    if (r_byte_rdy) w_asm_next = A_LO;
      A_LO:    if (r_byte_rdy || w_to_hit) w_asm_next = A_HI;
      default: w_asm_next = A_HI;
    endcase
  end

  always_comb begin
    w_hi_load  = (r_asm_state == A_HI) && r_byte_rdy;
    w_cmd_load = (r_asm_state == A_LO) && r_byte_rdy;
  end

  // Setting cmd_rdy outranks a coincident clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi      <= '0;
      r_cmd     <= '0;
      r_cmd_rdy <= 1'b0;
    end else begin
      if (w_hi_load) r_hi <= r_rx_shift;
      if (w_cmd_load) begin
        r_cmd     <= {r_hi, r_rx_shift};
        r_cmd_rdy <= 1'b1;
      end else if (w_hi_load || cmd_if.clr_cmd_rdy) begin
        r_cmd_rdy <= 1'b0;
      end
    end
  end

  assign cmd_if.cmd     = r_cmd;
  assign cmd_if.cmd_rdy = r_cmd_rdy;

  // ---------------- TX engine ----------------
  tx_state_t   r_tx_state, w_tx_next;
  logic [9:0]  r_tx_shift;
  logic [15:0] r_tx_cnt;
  logic [3:0]  r_tx_bits;
  logic        r_tx_done;
  logic        w_tx_tick, w_tx_load, w_tx_shift, w_tx_end;

  assign w_tx_tick = (r_tx_cnt == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_tx_state <= T_IDLE;
    else     r_tx_state <= w_tx_next;
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      T_IDLE:  if (cmd_if.trmt) w_tx_next = T_SHIFT;
      T_SHIFT: if (w_tx_tick && r_tx_bits == 4'd9) w_tx_next = T_IDLE;
      default: w_tx_next = T_IDLE;
    endcase
  end

  always_comb begin
    w_tx_load  = (r_tx_state == T_IDLE) && cmd_if.trmt;
    w_tx_shift = (r_tx_state == T_SHIFT) && w_tx_tick;
    w_tx_end   = w_tx_shift && (r_tx_bits == 4'd9);
  end

  // Ones shift in behind the frame, so bit 0 doubles as the idle-high line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '1;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
      r_tx_done  <= 1'b0;
    end else begin
      if (w_tx_load) begin
        r_tx_shift <= {1'b1, cmd_if.resp, 1'b0};
        r_tx_cnt   <= BAUD_FULL;
        r_tx_bits  <= '0;
        r_tx_done  <= 1'b0;
      end else if (w_tx_shift) begin
        r_tx_shift <= {1'b1, r_tx_shift[9:1]};
        r_tx_cnt   <= BAUD_FULL;
        r_tx_bits  <= r_tx_bits + 4'd1;
        if (w_tx_end) r_tx_done <= 1'b1;
      end else if (r_tx_state == T_SHIFT) begin
        r_tx_cnt <= r_tx_cnt - 16'd1;
      end else begin
        r_tx_cnt <= '0;
      end
    end
  end

  assign TX             = r_tx_shift[0];
  assign cmd_if.tx_done = r_tx_done;

endmodule

// File: tb/tb_uart_cmd_link.sv
// Directed bench for uart_cmd_link at 16 clocks per bit; commands checked through a scoreboard queue.
// Expected timeout result follows `CMD_TIMEOUT_EN.
module tb_uart_cmd_link;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  logic RX;
  logic TX;
  uart_cmd_link_if u_if ();

  uart_cmd_link #(.BAUD_DIV(BD)) dut (
    .clk    (clk),
    .rst    (rst),
    .RX     (RX),
    .TX     (TX),
    .cmd_if (u_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic        tx_q[$];
  logic        prev_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scoreboard: every rising cmd_rdy must match the next queued command.
  always @(negedge clk) begin
    if (u_if.cmd_rdy === 1'b1 && prev_rdy === 1'b0) begin
      if (exp_q.size() == 0) chk("cmd_rdy_unexpected", {31'd0, u_if.cmd_rdy}, 32'd0);
      else                   chk("cmd", {16'd0, u_if.cmd}, {16'd0, exp_q.pop_front()});
    end
    prev_rdy <= u_if.cmd_rdy;
  end

  // mode 1: check cmd_rdy latency around the stop sample; mode 2: clr_cmd_rdy coincident with set.
  task automatic send(input logic [7:0] data, input logic stop, input int mode);
    logic [9:0] fr;
    fr = {stop, data, 1'b0};
    for (int k = 0; k < 10 * BD; k++) begin
      RX = fr[k / BD];
      if (mode == 2) u_if.clr_cmd_rdy = (k == 155);
      if (mode == 1 && k == 155) chk("lat_before", {31'd0, u_if.cmd_rdy}, 32'd0);
      if (mode == 1 && k == 156) chk("lat_after",  {31'd0, u_if.cmd_rdy}, 32'd1);
      @(negedge clk);
    end
    u_if.clr_cmd_rdy = 1'b0;
  endtask

  task automatic idle(input int n);
    RX = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; RX = 1'b1;
    u_if.trmt = 1'b0; u_if.resp = 8'h00; u_if.clr_cmd_rdy = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_tx",      {31'd0, TX},           32'd1);
    chk("rst_cmd",     {16'd0, u_if.cmd},     32'd0);
    chk("rst_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
    chk("rst_tx_done", {31'd0, u_if.tx_done}, 32'd0);
    rst = 1'b0;
    idle(10);

    // Command receive with latency check, hold, and clear
    send(8'h12, 1'b1, 0);
    exp_q.push_back(16'h1234);
    send(8'h34, 1'b1, 1);
    chk("rx_cmd",     {16'd0, u_if.cmd},     32'h1234);
    chk("rx_rdy",     {31'd0, u_if.cmd_rdy}, 32'd1);
    idle(20);
    chk("rx_rdy_hold", {31'd0, u_if.cmd_rdy}, 32'd1);
    u_if.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    u_if.clr_cmd_rdy = 1'b0;
    chk("rx_rdy_clr", {31'd0, u_if.cmd_rdy}, 32'd0);
    idle(10);

    // Framing error then a valid command
    send(8'h12, 1'b0, 0);
    idle(32);
    chk("fe_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
    send(8'hAB, 1'b1, 0);
    chk("fe_rdy_hi", {31'd0, u_if.cmd_rdy}, 32'd0);
    chk("fe_cmd_hold", {16'd0, u_if.cmd}, 32'h1234);
    exp_q.push_back(16'hABCD);
    send(8'hCD, 1'b1, 0);
    idle(10);

    // Response with an ignored second trmt
    u_if.resp = 8'hA5;
    for (int b = 0; b < 10; b++)
      tx_q.push_back((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : u_if.resp[b - 1]);
    u_if.trmt = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 160; k++) begin
      u_if.trmt = (k == 50);
      if (k == 50) u_if.resp = 8'h00;
      if (k >= 9 && (k - 9) % BD == 0) chk("tx_bit", {31'd0, TX}, {31'd0, tx_q.pop_front()});
      if (k == 100) chk("tx_done_mid", {31'd0, u_if.tx_done}, 32'd0);
      if (k == 160) chk("tx_done_pre", {31'd0, u_if.tx_done}, 32'd0);
      if (k < 160) @(negedge clk);
    end
    @(negedge clk);
    chk("tx_done", {31'd0, u_if.tx_done}, 32'd1);
    chk("tx_idle", {31'd0, TX}, 32'd1);
    idle(20);
    chk("tx_no_retx", {31'd0, TX}, 32'd1);

    // Collisions: set vs clear, then a new high byte while cmd_rdy is up
    send(8'h5A, 1'b1, 0);
    exp_q.push_back(16'h5A5A);
    send(8'h5A, 1'b1, 2);
    chk("col_set_wins", {31'd0, u_if.cmd_rdy}, 32'd1);
    send(8'h01, 1'b1, 0);
    chk("col_hi_clr", {31'd0, u_if.cmd_rdy}, 32'd0);
    chk("col_cmd_hold", {16'd0, u_if.cmd}, 32'h5A5A);
    exp_q.push_back(16'h0102);
    send(8'h02, 1'b1, 0);
    idle(10);

    // Reset in the middle of an RX frame with TX busy and a high byte held
    send(8'h99, 1'b1, 0);
    u_if.resp = 8'h00;
    u_if.trmt = 1'b1;
    @(negedge clk);
    u_if.trmt = 1'b0;
    RX = 1'b0;
    repeat (40) @(negedge clk);
    chk("pre_rst_tx", {31'd0, TX}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_tx",      {31'd0, TX},           32'd1);
    chk("mid_rst_cmd",     {16'd0, u_if.cmd},     32'd0);
    chk("mid_rst_cmd_rdy", {31'd0, u_if.cmd_rdy}, 32'd0);
    chk("mid_rst_tx_done", {31'd0, u_if.tx_done}, 32'd0);
    @(negedge clk);
    RX = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(5);
    send(8'h60, 1'b1, 0);
    exp_q.push_back(16'h6000);
    send(8'h00, 1'b1, 0);
    idle(10);

    // Stale high byte
    send(8'h55, 1'b1, 0);
    idle(30 * BD + 2);
`ifdef CMD_TIMEOUT_EN
    send(8'h66, 1'b1, 0);
    exp_q.push_back(16'h6677);
    send(8'h77, 1'b1, 0);
`else
    exp_q.push_back(16'h5566);
    send(8'h66, 1'b1, 0);
    send(8'h77, 1'b1, 0);
`endif
    idle(10);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
